led_uart_top: RTL and testbench
===============================

// Module: led_uart_top
// PURPOSE
//  FPGA top level for the "RTL to Hello World" board design.
//  - On reset release, transmits the boot banner "Hello World\r\n" over a UART (8N1).
//  - Afterwards, echoes received UART bytes back to the host.
//  - Maps received ASCII hex digits onto the LED bank.
//  - Drives a reset indicator LED.
//  - Self-contained: internal baud generator, RX, TX, banner ROM and control FSM.
// PARAMETERS
//  NO_OF_LEDS    4           width of led bus (1..8)
//  CLK_FREQ_HZ   50_000_000  clk frequency (20 ns period)
//  BAUD          115200      UART bit rate
//  CLKS_PER_BIT  CLK_FREQ_HZ/BAUD (434, integer-truncated); localparam, not overridable
// PORTS
//  clk        in   1           system clock, all logic on rising edge
//  resetn     in   1           reset, asynchronous, active-low
//  ser_rx     in   1           UART receive line, idle high, asynchronous to clk
//  ser_tx     out  1           UART transmit line, idle high
//  led        out  NO_OF_LEDS  user LEDs, active-high
//  reset_led  out  1           high while reset is asserted
// BEHAVIOUR
//  Clock and reset (already decided): one clock; reset is asynchronous and active-low.
//  - resetn asserts asynchronously.
//  - Deassertion passes a 2-flop synchronizer; internal rst_n rises on the 2nd rising clk edge after resetn rises.
//  Reset values (while resetn=0):
//  - ser_tx=1, led=0, reset_led=1.
//  - TX/RX FSMs in IDLE; echo buffer empty.
//  reset_led = ~resetn, combinational.
//  RX (8N1, LSB first):
//  - ser_rx passes a 2-flop synchronizer.
//  - IDLE->START on a falling edge (sync'd line 0).
//  - START re-samples at CLKS_PER_BIT/2. If the line is 1, this is a glitch: return to IDLE.
//  - DATA samples 8 bits, each CLKS_PER_BIT apart at mid-bit.
//  - STOP samples at mid-stop-bit:
//    - stop=1: byte valid, pulse rx_valid for 1 clk.
//    - stop=0: framing error; byte discarded, no echo, no LED change.
//  - After STOP, return to IDLE; ready for a new start bit immediately.
//  TX (8N1, LSB first):
//  - States IDLE, START, DATA (8 bits), STOP; each bit held exactly CLKS_PER_BIT clks.
//  - The next byte may start on the clk after the stop bit ends (no extra idle).
//  Control FSM: BANNER -> RUN.
//  - BANNER:
//    - Entered on reset.
//    - The first start bit (ser_tx=0) begins on the rising edge after internal rst_n rises.
//    - Sends the 13 bytes 48 65 6C 6C 6F 20 57 6F 72 6C 64 0D 0A back-to-back, then goes to RUN.
//  - RUN: every valid RX byte is queued for echo.
//    - 1-entry echo buffer; TX starts from the buffer when TX is idle.
//    - A byte arriving while the buffer is full is dropped (overrun); the buffered byte is kept.
//  - Bytes received during BANNER are not echoed; their LED effect still applies.
//  LED mapping (applied on the clk after rx_valid):
//  - '0'-'9' (0x30-0x39) -> value 0-9.
//  - 'a'-'f' / 'A'-'F' -> value 10-15.
//  - led <= value[NO_OF_LEDS-1:0]; zero-extended if NO_OF_LEDS>4.
//  - Any other byte: led unchanged.
//  Reset mid-operation:
//  - All state aborts immediately; ser_tx forced to 1.
//  - Banner restarts from byte 0 after release.
// TESTING
//  T1 reset: resetn=0, ser_rx=1 for 100 ns -> ser_tx=1, led=0, reset_led=1.
//     Release -> reset_led=0 immediately; ser_tx falls on the 3rd rising edge after release.
//  T2 banner: from reset release, decode ser_tx at 434 clks/bit ->
//     exactly "Hello World\r\n" (13 bytes), then ser_tx stays 1.
//  T3 echo: after banner, send 0x5A on ser_rx ->
//     0x5A appears on ser_tx; its start bit begins within 1 bit time of RX stop-bit mid-sample.
//  T4 LED: send '7' -> led=4'b0111. Send 'F' -> led=4'b1111. Send 'x' -> led stays 4'b1111.
//  T5 errors: send a 0-ns...200-ns low glitch -> no RX byte.
//     Send byte with stop bit=0 -> no echo, led unchanged.
//  T6 mid-reset: assert resetn=0 during banner byte 5 ->
//     ser_tx=1 at once; after release, banner restarts with 'H'.

Source files
------------

// File: rtl/led_uart_top.sv
// led_uart_top: board top for the "RTL to Hello World" design.
//   On reset release, sends "Hello World\r\n" over an 8N1 UART. After that it
//   echoes every good received byte. Received ASCII hex digits are shown on the
//   LED bank.
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset (release is synchronized inside)
//   ser_rx     UART receive line, idle high, asynchronous to clk
//   ser_tx     UART transmit line, idle high (registered)
//   led        user LEDs, active-high, last hex digit received
//   reset_led  high while resetn is low
module led_uart_top #(
   parameter int NO_OF_LEDS  = 4,
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD        = 115200
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  ser_rx,
   output logic                  ser_tx,
   output logic [NO_OF_LEDS-1:0] led,
   output logic                  reset_led
);
   localparam int CPB  = CLK_FREQ_HZ / BAUD;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB + 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_t;
   typedef enum logic       {C_BANNER, C_RUN} ctl_st_t;

   assign reset_led = ~resetn;

   // Reset asserts at once; release reaches the logic on the 2nd clk edge.
   logic [1:0] rst_sync;
   logic       rst_n;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) rst_sync <= 2'b00;
      else         rst_sync <= {rst_sync[0], 1'b1};
   assign rst_n = rst_sync[1];

   // ---------------- RX ----------------
   // rx_sync[1:0] is the synchronizer, rx_sync[2] the previous synced value,
   // so a start bit is a real 1->0 transition (a low stop bit that caused a
   // framing error cannot retrigger a frame by itself).
   logic [2:0] rx_sync;
   uart_st_t   rx_st;
   logic [CW-1:0] rx_cnt;
   logic [2:0] rx_bit;
   logic [7:0] rx_sh;
   logic       rx_valid;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rx_sync  <= 3'b111;
         rx_st    <= S_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_sh    <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_sync  <= {rx_sync[1:0], ser_rx};
         rx_valid <= 1'b0;
         case (rx_st)
            S_IDLE:
               if (rx_sync[2] && !rx_sync[1]) begin
                  rx_st  <= S_START;
                  rx_cnt <= '0;
               end
            S_START:
               if (rx_cnt == CW'(HALF - 1)) begin
                  rx_cnt <= '0;
                  rx_bit <= '0;
                  rx_st  <= rx_sync[1] ? S_IDLE : S_DATA;  // high at mid-start: glitch
               end else rx_cnt <= rx_cnt + 1'b1;
            S_DATA:
               if (rx_cnt == CW'(CPB - 1)) begin
                  rx_cnt <= '0;
                  rx_sh  <= {rx_sync[1], rx_sh[7:1]};
                  if (rx_bit == 3'd7) rx_st <= S_STOP;
                  else                rx_bit <= rx_bit + 1'b1;
               end else rx_cnt <= rx_cnt + 1'b1;
            default:  // S_STOP: low stop bit is a framing error, byte dropped
               if (rx_cnt == CW'(CPB - 1)) begin
                  rx_cnt   <= '0;
                  rx_st    <= S_IDLE;
                  rx_valid <= rx_sync[1];
               end else rx_cnt <= rx_cnt + 1'b1;
         endcase
      end

   // ---------------- LED ----------------
   logic [3:0] hex_val;
   logic       hex_ok;
   always_comb begin
      hex_val = 4'd0;
      hex_ok  = 1'b1;
      if      (rx_sh >= 8'h30 && rx_sh <= 8'h39) hex_val = 4'(rx_sh - 8'h30);
      else if (rx_sh >= 8'h61 && rx_sh <= 8'h66) hex_val = 4'(rx_sh - 8'h57);
      else if (rx_sh >= 8'h41 && rx_sh <= 8'h46) hex_val = 4'(rx_sh - 8'h37);
      else                                       hex_ok  = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                  led <= '0;
      else if (rx_valid && hex_ok) led <= NO_OF_LEDS'(hex_val);

   // ---------------- Control ----------------
   function automatic logic [7:0] banner_rom(input logic [3:0] idx);
      case (idx)
         4'd0:  return 8'h48;
         4'd1:  return 8'h65;
         4'd2:  return 8'h6C;
         4'd3:  return 8'h6C;
         4'd4:  return 8'h6F;
         4'd5:  return 8'h20;
         4'd6:  return 8'h57;
         4'd7:  return 8'h6F;
         4'd8:  return 8'h72;
         4'd9:  return 8'h6C;
         4'd10: return 8'h64;
         4'd11: return 8'h0D;
         default: return 8'h0A;
      endcase
   endfunction

   ctl_st_t    ctl_st;
   logic [3:0] ban_idx;
   logic [7:0] echo_buf;
   logic       echo_full;
   uart_st_t   tx_st;
   logic [CW-1:0] tx_cnt;
   logic [2:0] tx_bit;
   logic [7:0] tx_sh;
   logic       tx_ready, tx_go;
   logic [7:0] tx_byte;

   // TX can take a byte when idle or on the last clk of a stop bit, so
   // consecutive frames run back-to-back.
   assign tx_ready = (tx_st == S_IDLE) || (tx_st == S_STOP && tx_cnt == CW'(CPB - 1));

   always_comb begin
      tx_go   = 1'b0;
      tx_byte = echo_buf;
      if (ctl_st == C_BANNER) begin
         tx_go   = tx_ready;
         tx_byte = banner_rom(ban_idx);
      end else tx_go = tx_ready && echo_full;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ctl_st    <= C_BANNER;
         ban_idx   <= '0;
         echo_buf  <= '0;
         echo_full <= 1'b0;
      end else begin
         if (ctl_st == C_BANNER && tx_go) begin
            ban_idx <= ban_idx + 1'b1;
            if (ban_idx == 4'd12) ctl_st <= C_RUN;
         end
         // A byte arriving while the buffer is full is lost, even if the
         // buffer drains on the same clk.
         if (ctl_st == C_RUN) begin
            if (tx_go) echo_full <= 1'b0;
            if (rx_valid && !echo_full) begin
               echo_buf  <= rx_sh;
               echo_full <= 1'b1;
            end
         end
      end

   // ---------------- TX ----------------
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         tx_st  <= S_IDLE;
         tx_cnt <= '0;
         tx_bit <= '0;
         tx_sh  <= '0;
         ser_tx <= 1'b1;
      end else if (tx_go) begin
         tx_st  <= S_START;
         tx_cnt <= '0;
         tx_sh  <= tx_byte;
         ser_tx <= 1'b0;
      end else begin
         case (tx_st)
            S_START:
               if (tx_cnt == CW'(CPB - 1)) begin
                  tx_cnt <= '0;
                  tx_bit <= '0;
                  tx_st  <= S_DATA;
                  ser_tx <= tx_sh[0];
               end else tx_cnt <= tx_cnt + 1'b1;
            S_DATA:
               if (tx_cnt == CW'(CPB - 1)) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     tx_st  <= S_STOP;
                     ser_tx <= 1'b1;
                  end else begin
                     tx_bit <= tx_bit + 1'b1;
                     tx_sh  <= {1'b0, tx_sh[7:1]};
                     ser_tx <= tx_sh[1];
                  end
               end else tx_cnt <= tx_cnt + 1'b1;
            S_STOP:
               if (tx_cnt == CW'(CPB - 1)) begin
                  tx_cnt <= '0;
                  tx_st  <= S_IDLE;
               end else tx_cnt <= tx_cnt + 1'b1;
            default: ser_tx <= 1'b1;
         endcase
      end
endmodule

// File: tb/tb_led_uart_top.sv
// Bench for led_uart_top. Runs at 1 Mbaud on the 50 MHz clock (50 clks/bit)
// so two full banners plus the echo traffic stay short.
module tb_led_uart_top;
   localparam int CLK_HZ  = 50_000_000;
   localparam int BAUD_TB = 1_000_000;
   localparam int CPB     = CLK_HZ / BAUD_TB;
   localparam int BIT_NS  = CPB * 20;

   logic       clk, resetn, ser_rx, ser_tx, reset_led;
   logic [3:0] led;

   led_uart_top #(.NO_OF_LEDS(4), .CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_TB)) dut (
      .clk(clk), .resetn(resetn), .ser_rx(ser_rx), .ser_tx(ser_tx),
      .led(led), .reset_led(reset_led)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int         n_chk, n_fail;
   time        t_fall, t_mid;
   logic [3:0] led_exp;
   logic [7:0] banner [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                               8'h6F, 8'h72, 8'h6C, 8'h64, 8'h0D, 8'h0A};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // LED reference: last hex digit value, other bytes leave it alone.
   function automatic logic [3:0] led_model(input logic [3:0] cur, input logic [7:0] c);
      if (c >= "0" && c <= "9") return 4'(c - "0");
      if (c >= "a" && c <= "f") return 4'(c - "a" + 10);
      if (c >= "A" && c <= "F") return 4'(c - "A" + 10);
      return cur;
   endfunction

   // Drive one 8N1 frame on ser_rx; stop_bit=0 builds a framing error.
   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      time t0;
      @(posedge clk);
      t0 = $time;
      t_mid = t0 + 9 * BIT_NS + BIT_NS / 2;
      ser_rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int k = 0; k < 8; k++) begin
         ser_rx = b[k];
         repeat (CPB) @(posedge clk);
      end
      ser_rx = stop_bit;
      repeat (CPB) @(posedge clk);
      ser_rx = 1'b1;
   endtask

   // Decode one frame from ser_tx; got=0 if no start bit within max_clks.
   // Returns at mid-stop-bit.
   task automatic get_tx(input int max_clks, output logic [7:0] b, output bit ok, output bit got);
      bit start_ok;
      got = 0; ok = 0; b = '0;
      for (int i = 0; i < max_clks; i++) begin
         @(negedge clk);
         if (ser_tx === 1'b0) begin got = 1; break; end
      end
      if (!got) return;
      t_fall = $time;
      repeat (CPB / 2) @(negedge clk);
      start_ok = (ser_tx === 1'b0);
      for (int k = 0; k < 8; k++) begin
         repeat (CPB) @(negedge clk);
         b[k] = ser_tx;
      end
      repeat (CPB) @(negedge clk);
      ok = start_ok && (ser_tx === 1'b1);
   endtask

   task automatic check_banner(input string tag, input int nbytes);
      logic [7:0] b; bit ok, got;
      for (int i = 0; i < nbytes; i++) begin
         get_tx(CPB * 12, b, ok, got);
         chk($sformatf("%s_byte%0d", tag, i), {22'd0, got, ok, b}, {22'd0, 2'b11, banner[i]});
      end
   endtask

   task automatic echo_byte(input logic [7:0] c);
      logic [7:0] b; bit ok, got;
      fork
         send_rx(c, 1'b1);
         get_tx(CPB * 14, b, ok, got);
      join
      chk($sformatf("echo_%02h", c), {22'd0, got, ok, b}, {22'd0, 2'b11, c});
      led_exp = led_model(led_exp, c);
      chk($sformatf("led_after_%02h", c), led, led_exp);
   endtask

   task automatic pulse_reset();
      resetn = 1'b0;
      #1;
      chk("rst_ser_tx", ser_tx, 1'b1);
      chk("rst_reset_led", reset_led, 1'b1);
      chk("rst_led", led, 4'd0);
      led_exp = 4'd0;
      #100;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      logic [7:0] b, c;
      bit ok, got, saw_low;
      n_chk = 0; n_fail = 0; led_exp = 4'd0;
      resetn = 1'b0; ser_rx = 1'b1;

      // reset values and release timing
      #100;
      chk("reset_ser_tx", ser_tx, 1'b1);
      chk("reset_led_bus", led, 4'd0);
      chk("reset_led_on", reset_led, 1'b1);
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("reset_led_off", reset_led, 1'b0);
      for (int e = 1; e <= 3; e++) begin
         @(posedge clk);
         #1;
         chk($sformatf("tx_after_edge%0d", e), ser_tx, (e == 3) ? 1'b0 : 1'b1);
      end

      // banner, then line stays idle
      check_banner("banner", 13);
      saw_low = 0;
      repeat (3 * CPB) begin
         @(negedge clk);
         if (ser_tx !== 1'b1) saw_low = 1;
      end
      chk("idle_after_banner", saw_low, 1'b0);

      // echo with start-bit latency
      echo_byte(8'h5A);
      chk("echo_latency", (t_fall >= t_mid) && (t_fall - t_mid <= BIT_NS), 1'b1);

      // LED mapping
      echo_byte("7");
      chk("led_7", led, 4'b0111);
      echo_byte("F");
      echo_byte("x");
      chk("led_x_keeps", led, 4'b1111);

      // random traffic, half of it hex digits
      for (int i = 0; i < 10; i++) begin
         int k;
         k = $urandom_range(0, 15);
         if ($urandom_range(0, 1) == 1)
            c = $urandom_range(0, 255);
         else if (k < 10)
            c = 8'(8'h30 + k);
         else
            c = ($urandom_range(0, 1) == 1) ? 8'(8'h61 + k - 10) : 8'(8'h41 + k - 10);
         echo_byte(c);
      end

      // short low glitches are not bytes
      for (int g = 0; g < 4; g++) begin
         int w;
         w = (g == 0) ? 200 : $urandom_range(0, 200);
         @(posedge clk);
         ser_rx = 1'b0;
         #(w);
         ser_rx = 1'b1;
         get_tx(CPB * 12, b, ok, got);
         chk($sformatf("glitch_%0dns_no_echo", w), got, 1'b0);
         chk("glitch_led", led, led_exp);
      end

      // framing error: no echo, no LED change, RX recovers afterwards
      fork
         send_rx("3", 1'b0);
         get_tx(CPB * 14, b, ok, got);
      join
      chk("framing_no_echo", got, 1'b0);
      chk("framing_led", led, led_exp);
      echo_byte("c");

      // reset during banner byte 5, banner restarts from 'H'
      pulse_reset();
      check_banner("banner2", 5);
      repeat (3 * CPB) @(negedge clk);
      pulse_reset();
      check_banner("banner3", 13);
      echo_byte("2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
